// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions: datapath width and fetch FSM state encoding.
package instr_fetch_pkg;

  localparam int DATA_W = 16;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_LOAD = 2'd2
  } fetch_state_e;

endpackage : instr_fetch_pkg

// File: rtl/pc_reg.sv
// Program counter: redirect load has priority over increment; increment wraps.
module pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic [DATA_W-1:0] din,
  input  logic              inc,
  output logic [DATA_W-1:0] pc
);

  // PC state: async reset, then load, increment (silent wrap) or hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (ld) begin
      pc <= din;
    end else if (inc) begin
      pc <= pc + 16'd1;
    end else begin
      pc <= pc;
    end
  end

endmodule : pc_reg

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE -> REQ (wait for memory, bounded) -> LOAD -> IDLE.
// Drives the external instruction register's Din/ld; owns the PC.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 16'h0000,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_ld,
  input  logic [DATA_W-1:0] pc_din,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] ir_din,
  output logic              ir_ld,
  output logic [DATA_W-1:0] pc,
  output logic              busy,
  output logic              fetch_err
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_inc;
  logic              timeout_hit;
  logic              pc_load;
  logic              pc_inc;

  // Redirects are honoured only while idle; the PC advances once per completed fetch
  assign pc_load  = (state == FS_IDLE) && pc_ld;
  assign pc_inc   = (state == FS_LOAD);
  assign mem_addr = pc;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .ld    (pc_load),
    .din   (pc_din),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a ready response beats a timeout in the same cycle
  always_comb begin
    state_next   = state;
    wait_cnt_inc = wait_cnt + 8'd1;
    timeout_hit  = 1'b0;
    case (state)
      FS_IDLE: begin
        if (fetch_req) begin
          state_next = FS_REQ;
        end else begin
          state_next = FS_IDLE;
        end
      end
      FS_REQ: begin
        if (mem_ready) begin
          state_next = FS_LOAD;
        end else if (wait_cnt_inc == TIMEOUT_CNT) begin
          state_next  = FS_IDLE;
          timeout_hit = 1'b1;
        end else begin
          state_next = FS_REQ;
        end
      end
      FS_LOAD: begin
        state_next = FS_IDLE;
      end
      default: begin
        state_next = FS_IDLE;
      end
    endcase
  end

  // Wait counter: counts consecutive not-ready REQ cycles, cleared otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if ((state == FS_REQ) && !mem_ready && !timeout_hit) begin
      wait_cnt <= wait_cnt_inc;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  // Instruction word capture; holds until the next successful read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_din <= 16'h0000;
    end else if ((state == FS_REQ) && mem_ready) begin
      ir_din <= mem_rdata;
    end else begin
      ir_din <= ir_din;
    end
  end

  // Output registers decoded from the next state so they line up with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd    <= 1'b0;
      ir_ld     <= 1'b0;
      busy      <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      mem_rd    <= (state_next == FS_REQ);
      ir_ld     <= (state_next == FS_LOAD);
      busy      <= (state_next != FS_IDLE);
      fetch_err <= timeout_hit;
    end
  end

endmodule : instr_fetch
